// File: rtl/can_pkg.sv
// Shared CAN receive-path definitions: destuffer state encoding and
// protocol constants used by the bit destuffer and its neighbours.
package can_pkg;

  typedef enum logic [1:0] {
    IDLE,
    COUNT,
    EXPECT_STUFF,
    ERROR
  } destuff_state_t;

  localparam int          CAN_STUFF_LEN  = 5;
  localparam logic [14:0] CAN_CRC15_POLY = 15'h4599;
  localparam logic        CAN_RECESSIVE  = 1'b1;

endpackage

// File: rtl/can_bit_destuff_if.sv
// Bit stream link between the bit-timing sampler (master) and the
// destuffer (slave); the destuffed outputs flow back towards the CRC stage.
interface can_bit_destuff_if;

  logic       sample_i;
  logic       rx_bit_i;
  logic       frame_start_i;
  logic       stuff_en_i;
  logic       bit_o;
  logic       bit_valid_o;
  logic       stuff_bit_o;
  logic       stuff_err_o;
  logic [7:0] stuff_cnt_o;

  modport master (
    output sample_i, rx_bit_i, frame_start_i, stuff_en_i,
    input  bit_o, bit_valid_o, stuff_bit_o, stuff_err_o, stuff_cnt_o
  );

  modport slave (
    input  sample_i, rx_bit_i, frame_start_i, stuff_en_i,
    output bit_o, bit_valid_o, stuff_bit_o, stuff_err_o, stuff_cnt_o
  );

endinterface

// File: rtl/can_bit_destuff.sv
// CAN receive bit destuffer: removes stuff bits inside the stuffing window,
// flags stuff errors (STUFF_LEN+1 equal bits) and forwards payload bits to
// the CRC stage. All outputs are registered, one clock after sample_i.
// Optional per-frame stuff-bit counter enabled by CAN_DESTUFF_STATS_EN.
module can_bit_destuff
  import can_pkg::*;
#(
  parameter int STUFF_LEN = CAN_STUFF_LEN,
  parameter int CNT_W     = 4
) (
  input  logic              clk_can_i,
  input  logic              rst_i,
  can_bit_destuff_if.slave  bus
);

  localparam logic [CNT_W-1:0] RUN_MAX = CNT_W'(STUFF_LEN);
  localparam logic [CNT_W-1:0] RUN_ONE = CNT_W'(1);

  destuff_state_t   state_reg;
  logic [CNT_W-1:0] run_cnt_reg;
  logic             last_bit_reg;
  logic             bit_reg;
  logic             bit_valid_reg;
  logic             stuff_bit_reg;
  logic             stuff_err_reg;

  // State as seen by the sample: a coincident frame_start clears first
  destuff_state_t   state_cur;
  logic [CNT_W-1:0] run_cur;
  logic             last_cur;
  logic             err_cur;
  logic             same_bit;
  logic [CNT_W-1:0] run_inc;
  logic             stuff_hit;

  // Apply the frame-start clear ahead of sample processing
  always_comb begin
    state_cur = state_reg;
    run_cur   = run_cnt_reg;
    last_cur  = last_bit_reg;
    err_cur   = stuff_err_reg;
    if (bus.frame_start_i) begin
      state_cur = bus.stuff_en_i ? COUNT : IDLE;
      run_cur   = '0;
      last_cur  = CAN_RECESSIVE;
      err_cur   = 1'b0;
    end
  end

  assign same_bit  = (bus.rx_bit_i == last_cur);
  assign run_inc   = same_bit ? (run_cur + RUN_ONE) : RUN_ONE;
  assign stuff_hit = bus.sample_i && bus.stuff_en_i &&
                     (state_cur == EXPECT_STUFF) && !same_bit;

  // Destuff FSM with registered outputs; only sample strobes advance it
  always_ff @(posedge clk_can_i or posedge rst_i) begin
    if (rst_i) begin
      state_reg     <= IDLE;
      run_cnt_reg   <= '0;
      last_bit_reg  <= CAN_RECESSIVE;
      bit_reg       <= 1'b0;
      bit_valid_reg <= 1'b0;
      stuff_bit_reg <= 1'b0;
      stuff_err_reg <= 1'b0;
    end else begin
      bit_valid_reg <= 1'b0;
      stuff_bit_reg <= 1'b0;
      state_reg     <= state_cur;
      run_cnt_reg   <= run_cur;
      last_bit_reg  <= last_cur;
      stuff_err_reg <= err_cur;
      if (bus.sample_i) begin
        if (state_cur != ERROR && !bus.stuff_en_i) begin
          // Outside the window: forward as-is and drop any pending expectation
          bit_reg       <= bus.rx_bit_i;
          bit_valid_reg <= 1'b1;
          state_reg     <= IDLE;
          run_cnt_reg   <= '0;
          last_bit_reg  <= bus.rx_bit_i;
        end else begin
          case (state_cur)
            IDLE: begin
              bit_reg       <= bus.rx_bit_i;
              bit_valid_reg <= 1'b1;
              state_reg     <= COUNT;
              run_cnt_reg   <= RUN_ONE;
              last_bit_reg  <= bus.rx_bit_i;
            end
            COUNT: begin
              bit_reg       <= bus.rx_bit_i;
              bit_valid_reg <= 1'b1;
              run_cnt_reg   <= run_inc;
              last_bit_reg  <= bus.rx_bit_i;
              if (run_inc == RUN_MAX) begin
                state_reg <= EXPECT_STUFF;
              end
            end
            EXPECT_STUFF: begin
              if (!same_bit) begin
                // Stuff bit is discarded but starts the next run
                stuff_bit_reg <= 1'b1;
                run_cnt_reg   <= RUN_ONE;
                last_bit_reg  <= bus.rx_bit_i;
                state_reg     <= COUNT;
              end else begin
                stuff_err_reg <= 1'b1;
                state_reg     <= ERROR;
              end
            end
            default: begin
            end
          endcase
        end
      end
    end
  end

  assign bus.bit_o       = bit_reg;
  assign bus.bit_valid_o = bit_valid_reg;
  assign bus.stuff_bit_o = stuff_bit_reg;
  assign bus.stuff_err_o = stuff_err_reg;

`ifdef CAN_DESTUFF_STATS_EN
  logic [7:0] stuff_cnt_reg;

  // Saturating count of stuff bits removed in the current frame
  always_ff @(posedge clk_can_i or posedge rst_i) begin
    if (rst_i) begin
      stuff_cnt_reg <= 8'd0;
    end else if (bus.frame_start_i) begin
      stuff_cnt_reg <= 8'd0;
    end else if (stuff_hit && stuff_cnt_reg != 8'hFF) begin
      stuff_cnt_reg <= stuff_cnt_reg + 8'd1;
    end
  end

  assign bus.stuff_cnt_o = stuff_cnt_reg;
`else
  logic unused_stuff_hit;
  assign unused_stuff_hit = stuff_hit;
  assign bus.stuff_cnt_o  = 8'd0;
`endif

endmodule

// File: tb/tb_can_bit_destuff.sv
// Randomized and directed bench for can_bit_destuff. The reference model
// keeps the recent in-window bus bits and applies the CAN rule directly:
// after STUFF_LEN equal bits the next bit must be their complement.
module tb_can_bit_destuff;

  localparam int SLEN = 5;

  logic clk_can_i = 1'b0;
  logic rst_i     = 1'b1;

  can_bit_destuff_if bus();

  can_bit_destuff #(.STUFF_LEN(SLEN), .CNT_W(4)) dut (
    .clk_can_i (clk_can_i),
    .rst_i     (rst_i),
    .bus       (bus)
  );

  always #5 clk_can_i = ~clk_can_i;

  int total = 0;
  int bad   = 0;

  // Reference model state
  bit hist[$];
  bit m_err;
  int m_cnt;
  bit m_bit, m_valid, m_stuff;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic bit run_full();
    if (hist.size() < SLEN) return 1'b0;
    for (int i = 0; i < hist.size(); i++)
      if (hist[i] != hist[0]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic push_bit(input bit b);
    hist.push_back(b);
    if (hist.size() > SLEN) void'(hist.pop_front());
  endtask

  task automatic model_reset();
    hist.delete();
    m_err = 0; m_cnt = 0; m_bit = 0; m_valid = 0; m_stuff = 0;
  endtask

  task automatic model_step(input bit s, input bit b, input bit fs, input bit en);
    m_valid = 0;
    m_stuff = 0;
    if (fs) begin
      hist.delete();
      m_err = 0;
      m_cnt = 0;
    end
    if (s && !m_err) begin
      if (!en) begin
        m_valid = 1; m_bit = b;
        hist.delete();
      end else if (run_full()) begin
        if (b != hist[hist.size()-1]) begin
          m_stuff = 1;
          if (m_cnt < 255) m_cnt++;
          push_bit(b);
        end else begin
          m_err = 1;
        end
      end else begin
        m_valid = 1; m_bit = b;
        push_bit(b);
      end
    end
  endtask

  task automatic check_outputs(input string tag);
    int exp_cnt;
`ifdef CAN_DESTUFF_STATS_EN
    exp_cnt = m_cnt;
`else
    exp_cnt = 0;
`endif
    chk({tag, ":valid"}, 32'(bus.bit_valid_o), 32'(m_valid));
    chk({tag, ":stuff"}, 32'(bus.stuff_bit_o), 32'(m_stuff));
    chk({tag, ":err"},   32'(bus.stuff_err_o), 32'(m_err));
    chk({tag, ":cnt"},   32'(bus.stuff_cnt_o), 32'(exp_cnt));
    chk({tag, ":bit"},   32'(bus.bit_o),       32'(m_bit));
  endtask

  task automatic step(input string tag, input bit s, input bit b, input bit fs, input bit en);
    @(negedge clk_can_i);
    bus.sample_i      = s;
    bus.rx_bit_i      = b;
    bus.frame_start_i = fs;
    bus.stuff_en_i    = en;
    model_step(s, b, fs, en);
    @(posedge clk_can_i);
    #1;
    check_outputs(tag);
    if (s)
      $display("%s: rx=%0b fs=%0b en=%0b -> bit=%0b valid=%0b stuff=%0b err=%0b cnt=%0d",
               tag, b, fs, en, bus.bit_o, bus.bit_valid_o, bus.stuff_bit_o,
               bus.stuff_err_o, bus.stuff_cnt_o);
  endtask

  // Frame start pulse without a sample, then the bits with a gap after each
  task automatic send_frame(input string tag, input bit seq[$], input bit en);
    step(tag, 1'b0, 1'b0, 1'b1, en);
    foreach (seq[i]) begin
      step(tag, 1'b1, seq[i], 1'b0, en);
      step(tag, 1'b0, 1'b0, 1'b0, en);
    end
  endtask

  initial begin
    bit q[$];
    bit c;
    bit b, en;
    int exp_sat;

    bus.sample_i = 0; bus.rx_bit_i = 0; bus.frame_start_i = 0; bus.stuff_en_i = 0;
    model_reset();
    repeat (3) @(negedge clk_can_i);
    check_outputs("reset");
    rst_i = 0;

    // Stuffed run
    q = '{0, 0, 0, 0, 0, 1, 0};
    send_frame("stuffed_run", q, 1'b1);

    // Stuff error, then samples ignored
    q = '{1, 1, 1, 1, 1, 1, 0, 1};
    send_frame("stuff_err", q, 1'b1);
    chk("stuff_err_sticky", 32'(bus.stuff_err_o), 32'd1);

    // Frame start coincident with a sample while in ERROR
    step("fs_in_error", 1'b1, 1'b0, 1'b1, 1'b1);
    chk("fs_in_error_valid", 32'(bus.bit_valid_o), 32'd1);
    q = '{0, 0, 0, 0, 1};
    foreach (q[i]) step("fs_in_error", 1'b1, q[i], 1'b0, 1'b1);

    // Stuff bit starts the next run
    q = '{1, 1, 1, 1, 1, 0, 0, 0, 0, 0, 0};
    send_frame("stuff_starts_run", q, 1'b1);
    chk("stuff_starts_run_err", 32'(bus.stuff_err_o), 32'd1);

    // Window exit after five equal bits
    q = '{1, 1, 1, 1, 1};
    send_frame("window_exit", q, 1'b1);
    step("window_exit", 1'b1, 1'b1, 1'b0, 1'b0);
    chk("window_exit_valid", 32'(bus.bit_valid_o), 32'd1);
    chk("window_exit_noerr", 32'(bus.stuff_err_o), 32'd0);

    // Reset mid-frame (asynchronous)
    step("pre_reset", 1'b0, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 5; i++) step("pre_reset", 1'b1, 1'b1, 1'b0, 1'b1);
    step("pre_reset", 1'b1, 1'b1, 1'b0, 1'b1);
    @(negedge clk_can_i);
    bus.sample_i = 0; bus.frame_start_i = 0;
    #2 rst_i = 1;
    #1;
    model_reset();
    check_outputs("async_reset");
    @(negedge clk_can_i);
    rst_i = 0;

    // Saturating stuff counter: 300 stuff bits in one frame
    step("stats", 1'b0, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 5; i++) step("stats", 1'b1, 1'b0, 1'b0, 1'b1);
    c = 1'b0;
    for (int k = 0; k < 300; k++) begin
      c = ~c;
      for (int i = 0; i < 5; i++) step("stats", 1'b1, c, 1'b0, 1'b1);
    end
`ifdef CAN_DESTUFF_STATS_EN
    exp_sat = 255;
`else
    exp_sat = 0;
`endif
    chk("stats_saturate", 32'(bus.stuff_cnt_o), 32'(exp_sat));
    step("stats_clear", 1'b0, 1'b0, 1'b1, 1'b1);
    chk("stats_clear", 32'(bus.stuff_cnt_o), 32'd0);

    // Randomized traffic with long runs, window toggles and frame starts
    b = 1'b0;
    en = 1'b1;
    for (int n = 0; n < 4000; n++) begin
      bit s, fs;
      s  = ($urandom_range(0, 3) != 0);
      fs = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 99) < 15) b = ~b;
      if ($urandom_range(0, 59) == 0) en = ~en;
      step("rand", s, b, fs, en);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global time limit so the run always ends
  initial begin
    #2000000;
    $display("FAIL timeout: got running want finished");
    $fatal(1, "time limit reached");
  end

endmodule

// File: doc/can_bit_destuff.md
Name: can_bit_destuff

Overview:
Receive-path bit destuffer between the bit-timing sampler and the CRC-15 accumulator. It consumes one sampled bus bit per bit time and removes CAN stuff bits, so that only payload bits (SOF through CRC field) reach the CRC stage. It detects stuff errors, meaning STUFF_LEN+1 equal consecutive bits inside the stuffing window. bit_o / bit_valid_o drive the CRC block's data_i / en_i directly.

Parameters:
STUFF_LEN, 5, run length of equal bits after which one complementary stuff bit is expected (legal range 2..15)
CNT_W, 4, width of the run counter; must hold STUFF_LEN

Ports:
clk_can_i  in  1  CAN core clock
rst_i  in  1  reset, asynchronous, active-high
sample_i  in  1  one-cycle strobe: rx_bit_i is valid this cycle (once per bit time)
rx_bit_i  in  1  sampled bus level (0 = dominant)
frame_start_i  in  1  one-cycle pulse at SOF detect; clears run state and error
stuff_en_i  in  1  high while stuffing applies (SOF..end of CRC sequence)
bit_o  out  1  destuffed bit
bit_valid_o  out  1  one-cycle pulse: bit_o is a payload bit (feeds CRC en_i)
stuff_bit_o  out  1  one-cycle pulse: sampled bit was a stuff bit and was discarded
stuff_err_o  out  1  sticky stuff-error flag
stuff_cnt_o  out  8  stuff bits removed in current frame (see Optional Feature)

Behaviour:
- Reset: all outputs 0; state IDLE; run_cnt = 0; last_bit = 1 (recessive).
- Latency: every output responds to a sample_i strobe one clock later, as a registered output. Only sample_i cycles advance state.
- States:
  IDLE: stuff_en_i low. Each sample is forwarded (bit_valid_o=1). run_cnt is held at 0. Go to COUNT on the first sample with stuff_en_i high.
  COUNT: on a sample, forward the bit. If bit==last_bit, run_cnt+1; otherwise run_cnt=1. last_bit=bit. When run_cnt reaches STUFF_LEN, go to EXPECT_STUFF.
  EXPECT_STUFF: on the next sample:
    bit != last_bit: discard the bit (bit_valid_o=0, stuff_bit_o=1); run_cnt=1; last_bit=bit; go to COUNT. The stuff bit starts the next run.
    bit == last_bit: stuff_err_o=1, the bit is not forwarded, go to ERROR.
  ERROR: all samples ignored; no bit_valid_o. Left only by frame_start_i or reset.
- Entry into COUNT from IDLE: the first sample gives run_cnt=1.
- stuff_en_i falling in COUNT or EXPECT_STUFF: go to IDLE on the next sample. A pending stuff expectation is dropped. The sample is forwarded unstuffed.
- frame_start_i: run_cnt=0, last_bit=1, stuff_err_o=0, stuff_cnt_o=0, state=COUNT if stuff_en_i is high, else IDLE.
- frame_start_i coinciding with sample_i: the clear is applied first, then the sample is processed as the first bit of the new frame (run_cnt=1).
- Outputs with sample_i low: bit_valid_o and stuff_bit_o are 0. bit_o holds its last value.
- Reset mid-frame: immediate return to the reset values, regardless of state.

Optional Feature:
CAN_DESTUFF_STATS_EN
- Defined: stuff_cnt_o increments on every stuff_bit_o pulse, saturates at 255, and clears on frame_start_i.
- Undefined: stuff_cnt_o is tied to 8'd0 and no counter logic is generated. The port list is identical in both cases.

Decomposition:
- can_pkg: destuff state enum (IDLE, COUNT, EXPECT_STUFF, ERROR), CAN_STUFF_LEN=5, CAN_CRC15_POLY=15'h4599, CAN_RECESSIVE=1'b1.
- No sub-module; the run counter is inline. In the top-level receiver, bit_valid_o connects to can_crc en_i and bit_o to data_i. The frame FSM drives crc_rst_i.

Test Plan:
- Stuffed run: frame_start, stuff_en=1, bits 0,0,0,0,0,1,0 -> five bit_valid pulses (all 0), then stuff_bit_o pulse on the 1, then bit_valid with bit_o=0; stuff_err_o=0.
- Stuff error: bits 1×6 with stuff_en=1 -> five valid pulses, then stuff_err_o=1 on the 6th sample; later samples give no bit_valid until frame_start_i.
- Stuff bit starts a run: 1,1,1,1,1,0,0,0,0,0 -> 0 is the stuff bit, so after four more 0s the state is EXPECT_STUFF; the next 0 raises stuff_err_o.
- Window exit: stuff_en drops after 5 equal bits, next sample equal -> forwarded with bit_valid=1, no error, no stuff pulse.
- frame_start_i coincident with sample (bit 0) while in ERROR -> stuff_err_o cleared, bit forwarded, run_cnt=1.
- STATS_EN: 300 stuff bits in one frame -> stuff_cnt_o=255. After frame_start_i -> 0. With the macro undefined, it stays 0 throughout.
